// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory: fetch (A) vs data (B), fixed LATENCY access window.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating tie-breaks; otherwise B wins every tie.
module mem_port_arbiter #(
    parameter int LATENCY = 3,
    parameter int CNT_W   = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic ReqA,
    input  logic ReqB,
    output logic GntA,
    output logic GntB,
    output logic DoneA,
    output logic DoneB,
    output logic Select,
    output logic MemEnable,
    output logic Busy
);

    typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic             START_DONE = (LATENCY == 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             gnt_a_n, gnt_b_n, done_a_n, done_b_n, sel_n, men_n;
    logic             pick_b;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_b, last_b_n;

    // Tie goes to whoever was not served last; last_b resets to 1 so A wins the first tie.
    assign pick_b = ~last_b;

    always_ff @(posedge Clk) begin
        if (Reset) last_b <= 1'b1;
        else       last_b <= last_b_n;
    end
`else
    assign pick_b = 1'b1;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        gnt_a_n  = GntA;
        gnt_b_n  = GntB;
        done_a_n = 1'b0;
        done_b_n = 1'b0;
        sel_n    = Select;
        men_n    = MemEnable;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_b_n = last_b;
`endif
        case (state)
            IDLE: begin
                if (ReqB && (!ReqA || pick_b)) begin
                    state_n  = BUSY_B;
                    gnt_b_n  = 1'b1;
                    sel_n    = 1'b1;
                    men_n    = 1'b1;
                    cnt_n    = CNT_LOAD;
                    done_b_n = START_DONE;
                end else if (ReqA) begin
                    state_n  = BUSY_A;
                    gnt_a_n  = 1'b1;
                    sel_n    = 1'b0;
                    men_n    = 1'b1;
                    cnt_n    = CNT_LOAD;
                    done_a_n = START_DONE;
                end
            end
            BUSY_A, BUSY_B: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    gnt_a_n = 1'b0;
                    gnt_b_n = 1'b0;
                    men_n   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_b_n = (state == BUSY_B);
`endif
                end else begin
                    // Done is registered, so it is raised on the edge that takes cnt to zero.
                    cnt_n    = cnt - 1'b1;
                    done_a_n = (state == BUSY_A) && (cnt == CNT_ONE);
                    done_b_n = (state == BUSY_B) && (cnt == CNT_ONE);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            GntA      <= 1'b0;
            GntB      <= 1'b0;
            DoneA     <= 1'b0;
            DoneB     <= 1'b0;
            Select    <= 1'b0;
            MemEnable <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            GntA      <= gnt_a_n;
            GntB      <= gnt_b_n;
            DoneA     <= done_a_n;
            DoneB     <= done_b_n;
            Select    <= sel_n;
            MemEnable <= men_n;
            Busy      <= (state_n != IDLE);
        end
    end

    a_gnt_excl: assert property (@(posedge Clk) disable iff (Reset) !(GntA && GntB));
    a_done_excl: assert property (@(posedge Clk) disable iff (Reset) !(DoneA && DoneB));
    a_sel_stable: assert property (@(posedge Clk) disable iff (Reset)
        (MemEnable && $past(MemEnable)) |-> (Select == $past(Select)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (LATENCY=3): directed scenarios with literal checks plus
// randomized protocol-following traffic compared against a grant-window model.
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic Clk, Reset, ReqA, ReqB;
    logic GntA, GntB, DoneA, DoneB, Select, MemEnable, Busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: current owner (0 none, 1 A, 2 B), grant cycles still to run, select, last-served.
    int   m_owner = 0;
    int   m_left  = 0;
    logic m_sel   = 1'b0;
    logic m_last_b = 1'b1;

    mem_port_arbiter #(.LATENCY(LAT), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .ReqA(ReqA), .ReqB(ReqB),
        .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
        .Select(Select), .MemEnable(MemEnable), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_done_a();
        return (m_owner == 1) && (m_left == 1);
    endfunction

    function automatic logic exp_done_b();
        return (m_owner == 2) && (m_left == 1);
    endfunction

    task automatic step_model(input logic a, input logic b, input logic r);
        int w;
        if (r) begin
            m_owner = 0; m_left = 0; m_sel = 1'b0; m_last_b = 1'b1;
        end else if (m_owner != 0) begin
            m_left--;
            if (m_left == 0) begin
                m_last_b = (m_owner == 2);
                m_owner  = 0;
            end
        end else if (a || b) begin
            if (a && b) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                w = m_last_b ? 1 : 2;
`else
                w = 2;
`endif
            end else begin
                w = a ? 1 : 2;
            end
            m_owner = w;
            m_left  = LAT;
            m_sel   = (w == 2);
        end
    endtask

    // Drive one edge's inputs, advance the model across that edge, then compare mid-cycle.
    task automatic cyc(input logic a, input logic b, input logic r);
        ReqA = a; ReqB = b; Reset = r;
        @(posedge Clk);
        step_model(a, b, r);
        @(negedge Clk);
        chk("GntA",      GntA,      m_owner == 1);
        chk("GntB",      GntB,      m_owner == 2);
        chk("DoneA",     DoneA,     exp_done_a());
        chk("DoneB",     DoneB,     exp_done_b());
        chk("Select",    Select,    m_sel);
        chk("MemEnable", MemEnable, m_owner != 0);
        chk("Busy",      Busy,      m_owner != 0);
    endtask

    initial begin
        logic ra, rb, rr;
        ReqA = 1'b0; ReqB = 1'b0; Reset = 1'b1;
        @(negedge Clk);

        // Reset state
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("rst_sel_lit", Select, 1'b0);
        chk("rst_busy_lit", Busy, 1'b0);

        // Single A request sampled at cycle 0
        cyc(1'b1, 1'b0, 1'b0);
        chk("single_gnta_c1_lit", GntA, 1'b1);
        chk("single_sel_c1_lit", Select, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("single_done_c2_lit", DoneA, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("single_done_c3_lit", DoneA, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("single_busy_c4_lit", Busy, 1'b0);
        chk("single_gnta_c4_lit", GntA, 1'b0);

        // B request for one cycle only: access still runs to completion
        cyc(1'b0, 1'b1, 1'b0);
        chk("drop_gntb_c1_lit", GntB, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("drop_doneb_c3_lit", DoneB, 1'b1);
        chk("drop_sel_c3_lit", Select, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("drop_sel_idle_hold_lit", Select, 1'b1);

        // Reset during cycle 2 of BUSY_A aborts without Done
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("abort_gnta_lit", GntA, 1'b0);
        chk("abort_donea_lit", DoneA, 1'b0);
        chk("abort_men_lit", MemEnable, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("regrant_gnta_lit", GntA, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("regrant_donea_lit", DoneA, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // Held tie, each requester drops for one cycle after its Done
        cyc(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            cyc(!exp_done_a(), !exp_done_b(), 1'b0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (k + 1 == 3)  chk("rr_done1_lit", DoneA, 1'b1);
            if (k + 1 == 7)  chk("rr_done2_lit", DoneB, 1'b1);
            if (k + 1 == 11) chk("rr_done3_lit", DoneA, 1'b1);
            if (k + 1 == 15) chk("rr_done4_lit", DoneB, 1'b1);
`else
            if (k + 1 == 3)  chk("fp_done1_lit", DoneB, 1'b1);
            if (k + 1 == 5)  chk("fp_gnta_never_lit", GntA, 1'b0);
            if (k + 1 == 7)  chk("fp_done2_lit", DoneB, 1'b1);
`endif
        end

        // Randomized traffic following the hold-until-Done protocol, with stray drops and resets
        ra = 1'b0; rb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (exp_done_a())                  ra = 1'b0;
            else if (!ra)                      ra = ($urandom_range(99) < 40);
            else if ($urandom_range(99) < 5)   ra = 1'b0;
            if (exp_done_b())                  rb = 1'b0;
            else if (!rb)                      rb = ($urandom_range(99) < 40);
            else if ($urandom_range(99) < 5)   rb = 1'b0;
            rr = ($urandom_range(199) == 0);
            cyc(ra, rb, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
